pll_reset_sequencer: RTL and testbench

//   Consumes the PLL 'locked' output and drives the PLL 'rst' input. Sequences PLL reset pulse, lock wait

---
 rtl/pll_reset_sequencer.sv | 90 +++++++++
 tb/tb_pll_reset_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock wait with timeout/retry, and lock-stability gating of sys_rst; ports clk/rst in, pll_locked/clear_status in, pll_rst/sys_rst/running/retry_count/lock_lost out (all registered)
module pll_reset_sequencer #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       running,
  output logic [7:0] retry_count,
  output logic       lock_lost
);
  localparam int CMAX = (RST_PULSE > LOCK_TIMEOUT) ?
                        ((RST_PULSE > STABLE_CYCLES) ? RST_PULSE : STABLE_CYCLES) :
                        ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = $clog2(CMAX);
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             retry_q, retry_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   running_q, running_d;
  logic                   locked_s, lost_set;
  assign locked_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    lost_set = 1'b0;
    sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    case (state_q)
      RESET_PLL: if (cnt_q == CW'(RST_PULSE - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = RESET_PLL;
          retry_d = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;
        end
      end
      STABLE: state_d = !locked_s ? WAIT_LOCK : (cnt_q == CW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
      RUN: begin
        if (!locked_s) begin
          state_d  = RESET_PLL;
          lost_set = 1'b1;
        end
      end
      default: state_d = RESET_PLL;
    endcase
    // counter restarts on every state change and idles in RUN so it never wraps
    cnt_d       = (state_d != state_q || state_q == RUN) ? '0 : cnt_q + 1'b1;
    lock_lost_d = lost_set | (lock_lost_q & ~clear_status);
    // outputs registered from the next state so they track the state flop exactly
    pll_rst_d   = (state_d == RESET_PLL);
    sys_rst_d   = (state_d != RUN);
    running_d   = (state_d == RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      sync_q      <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      running_q   <= running_d;
    end
  end
  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign running     = running_q;
  assign retry_count = retry_q;
  assign lock_lost   = lock_lost_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios plus random lock activity checked against a phase/age reference model
module tb_pll_reset_sequencer;
  localparam int RP = 4, TO = 32, SC = 8, SS = 2;
  logic       clk = 1'b0, rst = 1'b0, pll_locked = 1'b0, clear_status = 1'b0;
  logic       pll_rst, sys_rst, running, lock_lost;
  logic [7:0] retry_count;
  int errors = 0, checks = 0, ecount = 0;
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3;
  int m_ph, m_age, m_retry;
  bit m_lost;
  bit m_sync[$];
  pll_reset_sequencer #(.RST_PULSE(RP), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clear_status(clear_status),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .running(running),
    .retry_count(retry_count), .lock_lost(lock_lost)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, ecount, got, exp);
    end
  endtask
  task automatic model_reset();
    m_ph = P_RST; m_age = 0; m_retry = 0; m_lost = 0;
    m_sync = {};
    for (int i = 0; i < SS; i++) m_sync.push_back(1'b0);
  endtask
  task automatic enter(input int ph);
    m_ph = ph; m_age = 0;
  endtask
  task automatic model_step();
    bit ls, set;
    ls = m_sync[SS-1];
    void'(m_sync.pop_back());
    m_sync.push_front(pll_locked);
    set = 0;
    if (m_ph == P_RST) begin
      if (m_age + 1 == RP) enter(P_WAIT); else m_age++;
    end else if (m_ph == P_WAIT) begin
      if (ls) enter(P_STB);
      else if (m_age + 1 == TO) begin enter(P_RST); m_retry = (m_retry < 255) ? m_retry + 1 : 255; end
      else m_age++;
    end else if (m_ph == P_STB) begin
      if (!ls) enter(P_WAIT);
      else if (m_age + 1 == SC) enter(P_RUN);
      else m_age++;
    end else if (!ls) begin
      enter(P_RST); set = 1;
    end
    m_lost = set ? 1'b1 : (clear_status ? 1'b0 : m_lost);
  endtask
  task automatic compare_all();
    check("pll_rst", pll_rst, m_ph == P_RST);
    check("sys_rst", sys_rst, m_ph != P_RUN);
    check("running", running, m_ph == P_RUN);
    check("retry_count", retry_count, m_retry);
    check("lock_lost", lock_lost, m_lost);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    ecount++;
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    clear_status = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_running", running, 0);
    check("rst_retry", retry_count, 0);
    check("rst_lock_lost", lock_lost, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ecount = 0;
  endtask
  initial begin
    int hold;
    model_reset();
    @(negedge clk);
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      pll_locked = (e >= 10);
      cyc();
      if (ecount == 3) check("s1_pll_rst_hi", pll_rst, 1);
      if (ecount == 4) check("s1_pll_rst_lo", pll_rst, 0);
      if (ecount == 19) check("s1_sys_rst_hold", sys_rst, 1);
      if (ecount == 20) check("s1_sys_rst_rel", sys_rst, 0);
      if (ecount == 20) check("s1_running", running, 1);
    end
    pll_locked = 1'b0;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      pll_locked = (e >= 5) && !(e >= 13 && e <= 15);
      cyc();
      if (ecount == 15) check("s3_no_release", sys_rst, 1);
      if (ecount == 25) check("s3_sys_rst_hold", sys_rst, 1);
      if (ecount == 26) check("s3_sys_rst_rel", sys_rst, 0);
      if (ecount == 26) check("s3_retry", retry_count, 0);
    end
    pll_locked = 1'b0;
    cyc();
    cyc();
    check("s4_sys_rst_2edges", sys_rst, 0);
    cyc();
    check("s4_sys_rst_3edges", sys_rst, 1);
    check("s4_pll_rst_3edges", pll_rst, 1);
    check("s4_lock_lost", lock_lost, 1);
    pll_locked = 1'b1;
    repeat (20) cyc();
    check("s4_relock_running", running, 1);
    check("s4_lost_sticky", lock_lost, 1);
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    check("s4_cleared", lock_lost, 0);
    pll_locked = 1'b0;
    cyc();
    cyc();
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    check("s5_set_wins", lock_lost, 1);
    pll_locked = 1'b0;
    do_reset();
    while (ecount < 36 * 255 + 10) begin
      cyc();
      if (ecount == 36) check("s2_retry1", retry_count, 1);
      if (ecount == 36) check("s2_repulse", pll_rst, 1);
      if (ecount == 72) check("s2_retry2", retry_count, 2);
      if (ecount == 108) check("s2_retry3", retry_count, 3);
    end
    repeat (40) cyc();
    check("s2_saturate", retry_count, 255);
    do_reset();
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = $urandom_range(1, 45);
      end
      hold--;
      clear_status = ($urandom_range(0, 15) == 0);
      cyc();
    end
    clear_status = 1'b0;
    pll_locked = 1'b0;
    do_reset();
    repeat (80) cyc();
    check("s6_retry2", retry_count, 2);
    check("s6_in_wait", pll_rst, 0);
    do_reset();
    repeat (6) begin
      cyc();
      if (ecount == 3) check("s6_pll_rst_hi", pll_rst, 1);
      if (ecount == 4) check("s6_pll_rst_lo", pll_rst, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
